yuv_burst_writer: RTL and testbench
===================================

# yuv_burst_writer

Upstream feeder for the YUV BRAM address/ready stage. Accepts a pixel byte stream, and on each rising edge of the downstream `w_ready` writes one burst of exactly BURST_LEN words into the BRAM. For each word it drives `data_valid`, `bram_we`, `bram_addr` and `bram_din`. The burst word count and address wrap match the downstream 0..95 address counter, so both sides stay in lockstep.

## Interface
- DATA_W, 8, pixel/BRAM word width
- BURST_LEN, 96, words per burst (2..2^ADDR_W)
- ADDR_W, 7, BRAM address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_ready  in  1  downstream ready level; rising edge requests a burst
- pix_valid  in  1  upstream pixel present
- pix_data  in  DATA_W  upstream pixel byte
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- data_valid  out  1  one-cycle pulse per word written (feeds downstream data_valid)
- bram_we  out  1  BRAM write enable, identical to data_valid
- bram_addr  out  ADDR_W  BRAM write address
- bram_din  out  DATA_W  BRAM write data
- busy  out  1  high in BURST and DONE
- burst_cnt  out  16  completed bursts, wraps at 65535→0

## Operation
- States: IDLE, BURST, DONE.
- w_ready_d is w_ready registered. rise = w_ready && !w_ready_d.
- IDLE:
  - pix_ready=0.
  - rise or pend=1 → BURST, and clear pend.
- BURST:
  - pix_ready=1 (combinational from state).
  - Each accepted beat: the registered write stage loads addr→bram_addr, pix_data→bram_din, and sets data_valid=bram_we=1 next cycle. Otherwise data_valid=bram_we=0.
  - addr increments per accepted beat.
  - Beat at addr==BURST_LEN-1: addr←0, state→DONE.
  - w_ready is not consulted during BURST. Downstream drops w_ready near the end of the burst, and that must not truncate it.
- DONE:
  - Lasts one cycle; pix_ready=0; burst_cnt+1.
  - Then → IDLE.
- rise while busy: sets pend=1, so exactly one further burst follows. Multiple rises while busy still queue only one burst.
- bram_addr and bram_din hold their last value when no write is issued.
- Reset values: state IDLE, addr 0, pend 0, w_ready_d 0. All outputs 0 (pix_ready, data_valid, bram_we, bram_addr, bram_din, busy, burst_cnt, stall_cnt).
- If w_ready is already high at reset release, the first post-reset cycle detects a rise and starts a burst.
- Reset mid-burst: burst abandoned, no DONE, burst_cnt not incremented, next burst restarts at addr 0.

## Timing
- w_ready sampled high at edge T with w_ready_d=0 → busy=1 and pix_ready=1 from cycle T+1.
- Accept at edge N → data_valid/bram_we/bram_addr/bram_din valid during cycle N+1. Write latency is 1 cycle.
- With pix_valid held high, a burst issues writes on BURST_LEN consecutive cycles, addresses 0..BURST_LEN-1.
  - Last write pulse coincides with DONE.
  - burst_cnt updates at the end of DONE.
  - Earliest next burst start is the cycle after DONE.
- Stalls (pix_valid=0 in BURST) insert gaps in data_valid with no address advance and no wrap side effects.

## Configuration
- YUV_WR_STALL_CNT_EN defined:
  - Adds output stall_cnt [15:0], reset 0.
  - stall_cnt increments on every BURST cycle with pix_valid=0.
  - Saturates at 16'hFFFF; never cleared except by rst.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, w_ready 0→1, pix_valid=1 with data = addr+8'h10 → 96 pulses on data_valid, addresses 0..95, bram_din 8'h10..8'h6F. Then busy=0 and burst_cnt=1.
- Same burst with pix_valid low on every 4th BURST cycle → still exactly 96 writes, addresses contiguous 0..95. With YUV_WR_STALL_CNT_EN, stall_cnt equals the number of low cycles (e.g. 32).
- w_ready falls after 95 writes (downstream behaviour) → 96th write at addr 95 still issued, DONE taken, no extra writes.
- w_ready pulses low→high twice during a burst → exactly one extra burst, back-to-back after DONE; burst_cnt=2, then stays idle.
- rst asserted after 40 writes → all outputs 0 next cycle. New w_ready rise → burst restarts at addr 0 and burst_cnt counts from 0.
- w_ready held high through and after reset release → one burst starts on the first cycle after release, and no second burst without a fresh low→high.

Source files
------------

// File: rtl/yuv_burst_writer_if.sv
// Pixel-stream / BRAM-write bundle for yuv_burst_writer.
// YUV_WR_STALL_CNT_EN adds the stall_cnt status signal.
interface yuv_burst_writer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7
) ();
  logic              w_ready;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              data_valid;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic [15:0]       burst_cnt;
`ifdef YUV_WR_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    input  w_ready, pix_valid, pix_data,
    output pix_ready, data_valid, bram_we, bram_addr, bram_din, busy, burst_cnt
`ifdef YUV_WR_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport slave (
    output w_ready, pix_valid, pix_data,
    input  pix_ready, data_valid, bram_we, bram_addr, bram_din, busy, burst_cnt
`ifdef YUV_WR_STALL_CNT_EN
    , input stall_cnt
`endif
  );
endinterface

// File: rtl/yuv_burst_writer.sv
// Writes one BURST_LEN-word burst into the YUV BRAM per rising edge of w_ready.
// YUV_WR_STALL_CNT_EN adds a saturating count of stalled BURST cycles.
module yuv_burst_writer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 96,
  parameter int unsigned ADDR_W    = 7
) (
  input logic                 clk,
  input logic                 rst,
  yuv_burst_writer_if.master  wr_if
);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              w_ready_q;
  logic              dv_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic              rise;
  logic              accept;

  assign rise   = wr_if.w_ready & ~w_ready_q;
  assign accept = (state_q == StBurst) & wr_if.pix_valid;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise || pend_q) begin
          state_d = StBurst;
          pend_d  = 1'b0;
        end
      end
      StBurst: begin
        // w_ready only queues another burst here; it never ends this one
        if (rise) pend_d = 1'b1;
        if (accept) begin
          if (addr_q == LastAddr) begin
            addr_d  = '0;
            state_d = StDone;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (rise) pend_d = 1'b1;
        burst_cnt_d = burst_cnt_q + 16'd1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      w_ready_q   <= 1'b0;
      dv_q        <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      w_ready_q   <= wr_if.w_ready;
      dv_q        <= accept;
      burst_cnt_q <= burst_cnt_d;
      if (accept) begin
        bram_addr_q <= addr_q;
        bram_din_q  <= wr_if.pix_data;
      end
    end
  end

`ifdef YUV_WR_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StBurst) && !wr_if.pix_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign wr_if.stall_cnt = stall_cnt_q;
`endif

  assign wr_if.pix_ready  = (state_q == StBurst);
  assign wr_if.busy       = (state_q != StIdle);
  assign wr_if.data_valid = dv_q;
  assign wr_if.bram_we    = dv_q;
  assign wr_if.bram_addr  = bram_addr_q;
  assign wr_if.bram_din   = bram_din_q;
  assign wr_if.burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_yuv_burst_writer.sv
// Randomised bench for yuv_burst_writer: a burst-level reference model checked every cycle,
// plus literal end-of-scenario expectations.
module tb_yuv_burst_writer;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 96;
  localparam int ADDR_W    = 7;

  localparam int PH_IDLE  = 0;
  localparam int PH_BURST = 1;
  localparam int PH_DONE  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  yuv_burst_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b ();

  yuv_burst_writer #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_if (b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: burst phase, words written so far in this burst, queued request.
  int m_phase, m_words, m_bursts, m_stalls, m_ba, m_bd;
  bit m_pend, m_prev, m_dv;
  int wcount, first_ba;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic model_update(input bit wr, input bit pv, input int pd, input bit r);
    bit rise;
    if (r) begin
      m_phase = PH_IDLE; m_words = 0; m_bursts = 0; m_stalls = 0;
      m_ba = 0; m_bd = 0; m_pend = 0; m_prev = 0; m_dv = 0;
      return;
    end
    rise   = wr && !m_prev;
    m_prev = wr;
    m_dv   = 0;
    case (m_phase)
      PH_IDLE: if (rise || m_pend) begin m_phase = PH_BURST; m_pend = 0; end
      PH_BURST: begin
        if (rise) m_pend = 1;
        if (pv) begin
          m_dv = 1;
          m_ba = m_words;
          m_bd = pd;
          if (wcount == 0) first_ba = m_words;
          wcount++;
          m_words = (m_words + 1) % BURST_LEN;
          if (m_words == 0) m_phase = PH_DONE;
        end else if (m_stalls < 65535) begin
          m_stalls++;
        end
      end
      default: begin
        if (rise) m_pend = 1;
        m_bursts = (m_bursts + 1) % 65536;
        m_phase  = PH_IDLE;
      end
    endcase
  endtask

  task automatic compare();
    chk("pix_ready", 32'(b.pix_ready), 32'(m_phase == PH_BURST));
    chk("busy", 32'(b.busy), 32'(m_phase != PH_IDLE));
    chk("data_valid", 32'(b.data_valid), 32'(m_dv));
    chk("bram_we", 32'(b.bram_we), 32'(m_dv));
    chk("bram_addr", 32'(b.bram_addr), 32'(m_ba));
    chk("bram_din", 32'(b.bram_din), 32'(m_bd));
    chk("burst_cnt", 32'(b.burst_cnt), 32'(m_bursts));
`ifdef YUV_WR_STALL_CNT_EN
    chk("stall_cnt", 32'(b.stall_cnt), 32'(m_stalls));
`endif
  endtask

  // Inputs change on the falling edge, the model advances at the rising edge,
  // and DUT outputs are compared on the following falling edge.
  task automatic step(input bit wr, input bit pv, input logic [7:0] pd, input bit r);
    b.w_ready   = wr;
    b.pix_valid = pv;
    b.pix_data  = pd;
    rst         = r;
    @(posedge clk);
    model_update(wr, pv, int'(pd), r);
    @(negedge clk);
    compare();
  endtask

  task automatic run_to_idle(input string name, input int pv_pct);
    int i;
    for (i = 0; i < 600 && m_phase != PH_IDLE; i++)
      step(1'b1, ($urandom_range(99) < pv_pct), 8'($urandom), 1'b0);
    if (m_phase != PH_IDLE) timeout(name);
  endtask

  initial begin
    int k;
    bit wr;
    b.w_ready = 0; b.pix_valid = 0; b.pix_data = 0;
    wcount = 0; first_ba = -1;
    model_update(0, 0, 0, 1);
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Full burst, data = addr + 0x10
    wcount = 0; first_ba = -1;
    step(1, 1, 8'h10, 0);
    for (k = 0; k < 200 && m_phase != PH_IDLE; k++) step(1, 1, 8'(m_words + 16), 0);
    if (m_phase != PH_IDLE) timeout("burst1_idle");
    chk("b1_writes", 32'(wcount), 32'd96);
    chk("b1_first_addr", 32'(first_ba), 32'd0);
    chk("b1_last_addr", 32'(b.bram_addr), 32'd95);
    chk("b1_last_din", 32'(b.bram_din), 32'h6F);
    chk("b1_burst_cnt", 32'(b.burst_cnt), 32'd1);
    chk("b1_busy", 32'(b.busy), 32'd0);

    // pix_valid low on every 4th BURST cycle
    step(0, 0, 8'h00, 0);
    wcount = 0;
    step(1, 1, 8'h00, 0);
    for (k = 0; k < 300 && m_phase != PH_IDLE; k++) step(1, (k % 4 != 0), 8'($urandom), 0);
    if (m_phase != PH_IDLE) timeout("burst2_idle");
    chk("b2_writes", 32'(wcount), 32'd96);
    chk("b2_last_addr", 32'(b.bram_addr), 32'd95);
    chk("b2_burst_cnt", 32'(b.burst_cnt), 32'd2);
`ifdef YUV_WR_STALL_CNT_EN
    chk("b2_stall_cnt", 32'(b.stall_cnt), 32'd32);
`endif

    // w_ready drops after 95 writes; burst must still complete
    step(0, 0, 8'h00, 0);
    wcount = 0;
    step(1, 1, 8'h00, 0);
    for (k = 0; k < 200 && m_phase != PH_IDLE; k++) step((wcount < 95), 1, 8'($urandom), 0);
    if (m_phase != PH_IDLE) timeout("burst3_idle");
    for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
    chk("b3_writes", 32'(wcount), 32'd96);
    chk("b3_burst_cnt", 32'(b.burst_cnt), 32'd3);

    // Two extra rises during a burst queue exactly one more burst
    wcount = 0;
    step(1, 1, 8'h00, 0);
    for (k = 0; k < 700 && !(m_phase == PH_IDLE && !m_pend); k++) begin
      wr = !(k == 10 || k == 20);
      step(wr, ($urandom_range(99) < 75), 8'($urandom), 0);
    end
    if (!(m_phase == PH_IDLE && !m_pend)) timeout("burst4_idle");
    for (int i = 0; i < 10; i++) step(1, 1, 8'($urandom), 0);
    chk("b4_writes", 32'(wcount), 32'd192);
    chk("b4_burst_cnt", 32'(b.burst_cnt), 32'd5);

    // Reset after 40 writes, then a fresh burst from address 0
    step(0, 0, 8'h00, 0);
    wcount = 0;
    step(1, 1, 8'h00, 0);
    for (k = 0; k < 200 && wcount < 40; k++) step(1, 1, 8'($urandom), 0);
    if (wcount < 40) timeout("rst_mid_40");
    step(1, 1, 8'h55, 1);
    chk("rst_burst_cnt", 32'(b.burst_cnt), 32'd0);
    chk("rst_bram_addr", 32'(b.bram_addr), 32'd0);
    chk("rst_busy", 32'(b.busy), 32'd0);
    step(0, 0, 8'h00, 0);
    wcount = 0; first_ba = -1;
    step(1, 1, 8'h00, 0);
    run_to_idle("burst5_idle", 80);
    chk("b5_first_addr", 32'(first_ba), 32'd0);
    chk("b5_writes", 32'(wcount), 32'd96);
    chk("b5_burst_cnt", 32'(b.burst_cnt), 32'd1);

    // w_ready held high through reset release
    step(1, 0, 8'h00, 1);
    step(1, 0, 8'h00, 1);
    wcount = 0;
    step(1, 1, 8'h00, 0);
    chk("b6_busy_first", 32'(b.busy), 32'd1);
    run_to_idle("burst6_idle", 100);
    for (int i = 0; i < 20; i++) step(1, 1, 8'($urandom), 0);
    chk("b6_writes", 32'(wcount), 32'd96);
    chk("b6_burst_cnt", 32'(b.burst_cnt), 32'd1);

    // Random traffic
    wr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 8) wr = !wr;
      step(wr, ($urandom_range(99) < 70), 8'($urandom), ($urandom_range(999) < 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
